reconstruct_l3: RTL and testbench



---
 rtl/wavelet_pkg.sv | 18 +
 rtl/recon_phase_mac.sv | 36 +++
 rtl/reconstruct_l3.sv | 133 +++++++++++++
 tb/tb_reconstruct_l3.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wavelet_pkg.sv
// Shared widths and sym4 synthesis filter taps (Q1.23, index 0 first tap) for the wavelet datapath.
package wavelet_pkg;

  localparam int INTERNAL_WIDTH_DEF = 48;
  localparam int COEF_WIDTH_DEF     = 25;
  localparam int COEF_FRAC_DEF      = 23;

  localparam logic [7:0][COEF_WIDTH_DEF-1:0] REC_LO = {
    -25'sd635569, -25'sd248601, 25'sd4174328, 25'sd6742249,
     25'sd2498612, -25'sd832314, -25'sd105730, 25'sd270307
  };

  localparam logic [7:0][COEF_WIDTH_DEF-1:0] REC_HI = {
    -25'sd270307, -25'sd105730, 25'sd832314, 25'sd2498612,
    -25'sd6742249, 25'sd4174328, 25'sd248601, -25'sd635569
  };

endpackage

// File: rtl/recon_phase_mac.sv
// One output phase: 8 products registered, then their sum registered (2 cycles, always accepts).
module recon_phase_mac
  import wavelet_pkg::*;
#(
  parameter int              W     = INTERNAL_WIDTH_DEF,
  parameter int              CW    = COEF_WIDTH_DEF,
  parameter logic [8*CW-1:0] COEFS = '0
) (
  input  logic                    clk,
  input  logic [7:0][W-1:0]       samp,
  output logic signed [W+CW+3:0]  sum
);

  localparam int PW = W + CW;
  localparam int SW = PW + 4;

  logic signed [PW-1:0] prod_q [8];
  logic signed [SW-1:0] acc;

  // Datapath carries no reset; the valid pipe in the parent decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      prod_q[i] <= PW'($signed(samp[i])) * PW'($signed(COEFS[i*CW +: CW]));
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < 8; i++)
      acc = acc + SW'(prod_q[i]);
  end

  always_ff @(posedge clk) begin
    sum <= acc;
  end

endmodule

// File: rtl/reconstruct_l3.sv
// Level-3 inverse DWT to a2: each beat yields O(n),E(n),O(n-1),E(n-1); 3-cycle latency.
// Accepts a beat every cycle with no backpressure; the first two beats after reset only prime history.
module reconstruct_l3
  import wavelet_pkg::*;
#(
  parameter int INTERNAL_WIDTH = INTERNAL_WIDTH_DEF,
  parameter int COEF_WIDTH     = COEF_WIDTH_DEF,
  parameter int COEF_FRAC      = COEF_FRAC_DEF,
  parameter logic signed [COEF_WIDTH-1:0] REC_G0 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G1 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G2 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G3 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G4 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G5 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G6 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_G7 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H0 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H1 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H2 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H3 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H4 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H5 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H6 = '0,
  parameter logic signed [COEF_WIDTH-1:0] REC_H7 = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             din_valid,
  input  logic signed [INTERNAL_WIDTH-1:0] a3_0,
  input  logic signed [INTERNAL_WIDTH-1:0] a3_1,
  input  logic signed [INTERNAL_WIDTH-1:0] d3_0,
  input  logic signed [INTERNAL_WIDTH-1:0] d3_1,
  output logic                             dout_valid,
  output logic signed [INTERNAL_WIDTH-1:0] a2r_0,
  output logic signed [INTERNAL_WIDTH-1:0] a2r_1,
  output logic signed [INTERNAL_WIDTH-1:0] a2r_2,
  output logic signed [INTERNAL_WIDTH-1:0] a2r_3,
  output logic                             sat_flag
);

  localparam int W  = INTERNAL_WIDTH;
  localparam int CW = COEF_WIDTH;
  localparam int SW = W + CW + 4;

  localparam logic [8*CW-1:0] C_EVEN = {REC_H6, REC_H4, REC_H2, REC_H0, REC_G6, REC_G4, REC_G2, REC_G0};
  localparam logic [8*CW-1:0] C_ODD  = {REC_H7, REC_H5, REC_H3, REC_H1, REC_G7, REC_G5, REC_G3, REC_G1};

  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (COEF_FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -(SW'(1) <<< (W - 1));

  // a_h0/a_h1 = a[n-2]/a[n-3] from the previous beat; a_h2 = a[n-4] from the one before.
  logic signed [W-1:0] a_h0, a_h1, a_h2, d_h0, d_h1, d_h2;
  logic [1:0]          fill;
  logic [1:0]          vld_q;

  logic [7:0][W-1:0]   samp_n, samp_n1;
  logic signed [SW-1:0] sum_q   [4];
  logic signed [SW-1:0] shifted [4];
  logic signed [W-1:0]  res     [4];
  logic [3:0]           ovf;

  assign samp_n  = {d_h1, d_h0, d3_1, d3_0, a_h1, a_h0, a3_1, a3_0};
  assign samp_n1 = {d_h2, d_h1, d_h0, d3_1, a_h2, a_h1, a_h0, a3_1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_h0  <= '0;
      a_h1  <= '0;
      a_h2  <= '0;
      d_h0  <= '0;
      d_h1  <= '0;
      d_h2  <= '0;
      fill  <= '0;
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[0], din_valid && (fill == 2'd2)};
      if (din_valid) begin
        a_h2 <= a_h0;
        a_h1 <= a3_1;
        a_h0 <= a3_0;
        d_h2 <= d_h0;
        d_h1 <= d3_1;
        d_h0 <= d3_0;
        if (fill != 2'd2)
          fill <= fill + 2'd1;
      end
    end
  end

  recon_phase_mac #(.W(W), .CW(CW), .COEFS(C_ODD))  u_odd_n   (.clk(clk), .samp(samp_n),  .sum(sum_q[0]));
  recon_phase_mac #(.W(W), .CW(CW), .COEFS(C_EVEN)) u_even_n  (.clk(clk), .samp(samp_n),  .sum(sum_q[1]));
  recon_phase_mac #(.W(W), .CW(CW), .COEFS(C_ODD))  u_odd_n1  (.clk(clk), .samp(samp_n1), .sum(sum_q[2]));
  recon_phase_mac #(.W(W), .CW(CW), .COEFS(C_EVEN)) u_even_n1 (.clk(clk), .samp(samp_n1), .sum(sum_q[3]));

  // Round half up, then clamp to the signed output range.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      shifted[i] = (sum_q[i] + RND) >>> COEF_FRAC;
      res[i]     = shifted[i][W-1:0];
      ovf[i]     = 1'b0;
      if (shifted[i] > MAXV) begin
        res[i] = MAXV[W-1:0];
        ovf[i] = 1'b1;
      end else if (shifted[i] < MINV) begin
        res[i] = MINV[W-1:0];
        ovf[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      a2r_0      <= '0;
      a2r_1      <= '0;
      a2r_2      <= '0;
      a2r_3      <= '0;
      sat_flag   <= 1'b0;
    end else begin
      dout_valid <= vld_q[1];
      if (vld_q[1]) begin
        a2r_0 <= res[0];
        a2r_1 <= res[1];
        a2r_2 <= res[2];
        a2r_3 <= res[3];
        if (|ovf)
          sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reconstruct_l3.sv
// Scoreboard bench: two instances (sym4 taps and all-unity taps) against a sequence-level reference model.
module tb_reconstruct_l3;
  import wavelet_pkg::*;

  localparam int W = 48;
  typedef logic [7:0][24:0] coef_t;
  localparam coef_t CONE = {8{25'd8388608}};

  typedef struct packed {
    logic [31:0]      due;
    logic [3:0][47:0] v;
    logic             sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic din_valid = 1'b0;
  logic signed [W-1:0] a3_0 = '0, a3_1 = '0, d3_0 = '0, d3_1 = '0;
  logic dv [2];
  logic sf [2];
  logic signed [W-1:0] r [2][4];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic signed [W-1:0] as_q[$], ds_q[$];
  int   beats = 0;
  exp_t q0[$], q1[$];
  exp_t last_e [2];
  logic [1:0] sat_acc = '0;

  reconstruct_l3 #(
    .REC_G0(REC_LO[0]), .REC_G1(REC_LO[1]), .REC_G2(REC_LO[2]), .REC_G3(REC_LO[3]),
    .REC_G4(REC_LO[4]), .REC_G5(REC_LO[5]), .REC_G6(REC_LO[6]), .REC_G7(REC_LO[7]),
    .REC_H0(REC_HI[0]), .REC_H1(REC_HI[1]), .REC_H2(REC_HI[2]), .REC_H3(REC_HI[3]),
    .REC_H4(REC_HI[4]), .REC_H5(REC_HI[5]), .REC_H6(REC_HI[6]), .REC_H7(REC_HI[7])
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid),
    .a3_0(a3_0), .a3_1(a3_1), .d3_0(d3_0), .d3_1(d3_1),
    .dout_valid(dv[0]), .a2r_0(r[0][0]), .a2r_1(r[0][1]), .a2r_2(r[0][2]), .a2r_3(r[0][3]),
    .sat_flag(sf[0])
  );

  reconstruct_l3 #(
    .REC_G0(25'sd8388608), .REC_G1(25'sd8388608), .REC_G2(25'sd8388608), .REC_G3(25'sd8388608),
    .REC_G4(25'sd8388608), .REC_G5(25'sd8388608), .REC_G6(25'sd8388608), .REC_G7(25'sd8388608),
    .REC_H0(25'sd8388608), .REC_H1(25'sd8388608), .REC_H2(25'sd8388608), .REC_H3(25'sd8388608),
    .REC_H4(25'sd8388608), .REC_H5(25'sd8388608), .REC_H6(25'sd8388608), .REC_H7(25'sd8388608)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid),
    .a3_0(a3_0), .a3_1(a3_1), .d3_0(d3_0), .d3_1(d3_1),
    .dout_valid(dv[1]), .a2r_0(r[1][0]), .a2r_1(r[1][1]), .a2r_2(r[1][2]), .a2r_3(r[1][3]),
    .sat_flag(sf[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: a2 output samples straight from the sample streams, a[m] newest at the back.
  function automatic exp_t calc(input coef_t g, input coef_t h, input logic sat_in, input int due);
    exp_t e;
    logic signed [79:0] acc, xa, xd, cg, chh, rr;
    int idx, off, p;
    e.due = due;
    e.sat = sat_in;
    e.v = '0;
    for (int o = 0; o < 4; o++) begin
      off = o / 2;
      p = (o % 2 == 0) ? 1 : 0;
      acc = '0;
      for (int k = 0; k < 4; k++) begin
        idx = as_q.size() - 1 - off - k;
        if (idx >= 0) begin
          xa = as_q[idx];
          xd = ds_q[idx];
        end else begin
          xa = '0;
          xd = '0;
        end
        cg  = $signed(g[2*k+p]);
        chh = $signed(h[2*k+p]);
        acc = acc + xa * cg + xd * chh;
      end
      rr = (acc + 80'sd4194304) >>> 23;
      if (rr > 80'sh7fff_ffff_ffff) begin
        e.v[o] = 48'h7fff_ffff_ffff;
        e.sat = 1'b1;
      end else if (rr < -80'sh8000_0000_0000) begin
        e.v[o] = 48'h8000_0000_0000;
        e.sat = 1'b1;
      end else begin
        e.v[o] = rr[47:0];
      end
    end
    return e;
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       rnd48 = t[47:0];
      1:       rnd48 = {{28{t[20]}}, t[19:0]};
      2:       rnd48 = t[0] ? 48'h7fff_ffff_ffff : 48'h8000_0000_0000;
      default: rnd48 = '0;
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic beat(input logic v, input logic [47:0] a0, input logic [47:0] a1,
                      input logic [47:0] d0, input logic [47:0] d1);
    exp_t e;
    din_valid = v;
    a3_0 = a0;
    a3_1 = a1;
    d3_0 = d0;
    d3_1 = d1;
    if (v) begin
      as_q.push_back(a1);
      as_q.push_back(a0);
      ds_q.push_back(d1);
      ds_q.push_back(d0);
      beats++;
      if (beats > 2) begin
        e = calc(REC_LO, REC_HI, sat_acc[0], cyc + 3);
        sat_acc[0] = e.sat;
        q0.push_back(e);
        e = calc(CONE, CONE, sat_acc[1], cyc + 3);
        sat_acc[1] = e.sat;
        q1.push_back(e);
      end
      while (as_q.size() > 8) begin
        void'(as_q.pop_front());
        void'(ds_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rbeat(input logic v);
    beat(v, rnd48(), rnd48(), rnd48(), rnd48());
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    din_valid = 1'b0;
    q0.delete();
    q1.delete();
    as_q.delete();
    ds_q.delete();
    beats = 0;
    sat_acc = '0;
    last_e[0] = '0;
    last_e[1] = '0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset dout_valid", i), 48'(dv[i]), 48'd0);
      chk($sformatf("u%0d reset sat_flag", i), 48'(sf[i]), 48'd0);
      for (int k = 0; k < 4; k++)
        chk($sformatf("u%0d reset a2r_%0d", i, k), r[i][k], 48'd0);
    end
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic mon(input int i);
    exp_t e;
    logic hit;
    hit = 1'b0;
    e = '0;
    if (i == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        e = q0.pop_front();
        hit = 1'b1;
      end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        hit = 1'b1;
      end
    end
    chk($sformatf("u%0d dout_valid", i), 48'(dv[i]), 48'(hit));
    if (hit) last_e[i] = e;
    for (int k = 0; k < 4; k++)
      chk($sformatf("u%0d a2r_%0d", i, k), r[i][k], last_e[i].v[k]);
    chk($sformatf("u%0d sat_flag", i), 48'(sf[i]), 48'(last_e[i].sat));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    last_e[0] = '0;
    last_e[1] = '0;
    @(posedge clk);
    #1;
    do_reset(3);

    // priming: only the third beat produces output
    repeat (3) rbeat(1'b1);
    repeat (6) rbeat(1'b0);

    // approximation impulse
    repeat (2) beat(1'b1, '0, '0, '0, '0);
    beat(1'b1, 48'd8388608, '0, '0, '0);
    repeat (3) beat(1'b1, '0, '0, '0, '0);
    repeat (4) rbeat(1'b0);

    // detail impulse on the older sample
    repeat (2) beat(1'b1, '0, '0, '0, '0);
    beat(1'b1, '0, '0, '0, 48'd8388608);
    repeat (3) beat(1'b1, '0, '0, '0, '0);
    repeat (4) rbeat(1'b0);

    // bubbles
    repeat (4) begin
      rbeat(1'b1); rbeat(1'b0); rbeat(1'b0); rbeat(1'b1); rbeat(1'b1);
    end
    repeat (4) rbeat(1'b0);

    // saturation both ways, then back to zero
    repeat (3) beat(1'b1, 48'h7fff_ffff_ffff, 48'h7fff_ffff_ffff, 48'h7fff_ffff_ffff, 48'h7fff_ffff_ffff);
    repeat (4) beat(1'b1, '0, '0, '0, '0);
    repeat (3) beat(1'b1, 48'h8000_0000_0000, 48'h8000_0000_0000, 48'h8000_0000_0000, 48'h8000_0000_0000);
    repeat (4) beat(1'b1, '0, '0, '0, '0);
    repeat (4) rbeat(1'b0);

    // reset one cycle after an accepted beat, then re-prime
    repeat (3) rbeat(1'b1);
    do_reset(2);
    repeat (3) rbeat(1'b1);
    repeat (5) rbeat(1'b0);

    // random traffic
    for (int n = 0; n < 400; n++)
      rbeat($urandom_range(0, 9) < 7);

    repeat (8) rbeat(1'b0);
    chk("scoreboard drained", 48'(q0.size() + q1.size()), 48'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
